scc_data_mem: RTL and testbench

Data-side memory responder for the single-cycle computer (SCC): services the SCC's data-port loads and stores out of a word-addressed RAM and a small memory-mapped I/O window. The MMIO window holds a free-running cycle counter, a console transmit FIFO drained by an external valid/ready sink, and a status register. It sits beside the SCC in the top level, on the opposite end of the SCC's data_addr / data_out / data_read / data_write / data_in interface.

---
 rtl/scc_data_mem.sv | 139 +++++++++++++
 tb/tb_scc_data_mem.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/scc_data_mem.sv
// Data-side memory responder for the SCC: word RAM plus an MMIO window holding CYCLE, CON_TX and STATUS.
// Build option: define DMEM_CYCLE_COUNTER_EN to include the free-running CYCLE counter (reads 0 otherwise).
module scc_data_mem #(
  parameter int          DEPTH      = 256,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_out,
  input  logic        data_read,
  input  logic        data_write,
  output logic [31:0] data_in,
  output logic [31:0] con_data,
  output logic        con_valid,
  input  logic        con_ready,
  output logic        err
);

  localparam int          AW        = $clog2(DEPTH);
  localparam int          FW        = $clog2(FIFO_DEPTH);
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH) << 2;
  localparam logic [FW:0] FULL_CNT  = (FW + 1)'(FIFO_DEPTH);
  localparam logic [7:0]  OFF_CYCLE = 8'h00;
  localparam logic [7:0]  OFF_CONTX = 8'h04;
  localparam logic [7:0]  OFF_STAT  = 8'h08;

  logic [31:0] r_mem  [DEPTH];
  logic [31:0] r_fifo [FIFO_DEPTH];
  logic [FW-1:0] r_head;
  logic [FW-1:0] r_tail;
  logic [FW:0]   r_count;
  logic          r_ovf;
  logic          r_err;

  logic [AW-1:0] w_idx;
  logic [7:0]    w_off;
  logic          w_isRam;
  logic          w_isMmio;
  logic          w_regOk;
  logic          w_fault;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_pushOk;
  logic          w_ovfClr;
  logic          w_ramWe;
  logic [31:0]   w_cycle;
  logic [31:0]   w_status;
  logic [31:0]   w_rdata;

  assign w_idx    = data_addr[AW+1:2];
  assign w_off    = data_addr[7:0];
  assign w_isRam  = ({1'b0, data_addr} < RAM_BYTES);
  assign w_isMmio = (data_addr[31:8] == MMIO_BASE[31:8]);
  assign w_regOk  = w_isMmio && (w_off == OFF_CYCLE || w_off == OFF_CONTX || w_off == OFF_STAT);

  // Only an actual access can fault; an idle bus with a stray address is harmless.
  assign w_fault  = (data_read || data_write) &&
                    ((data_addr[1:0] != 2'b00) || !(w_isRam || w_regOk) || (data_read && data_write));

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == FULL_CNT);
  assign w_pop    = !w_empty && con_ready;
  assign w_push   = data_write && !w_fault && w_isMmio && (w_off == OFF_CONTX);
  assign w_pushOk = w_push && (!w_full || w_pop);
  assign w_ovfClr = data_write && !w_fault && w_isMmio && (w_off == OFF_STAT) && data_out[2];
  assign w_ramWe  = data_write && !w_fault && w_isRam && !reset;

  assign w_status = {16'h0000, 8'(r_count), 4'h0, r_err, r_ovf, w_full, w_empty};

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] r_cycle;

  always_ff @(posedge clk) begin
    if (reset) r_cycle <= '0;
    else       r_cycle <= r_cycle + 32'd1;
  end

  assign w_cycle = r_cycle;
`else
  assign w_cycle = '0;
`endif

  always_ff @(posedge clk) begin
    if (w_ramWe) r_mem[w_idx] <= data_out;
  end

  always_ff @(posedge clk) begin
    if (!reset && w_pushOk) r_fifo[r_tail] <= data_out;
  end

  // A push into a full FIFO only succeeds when the sink frees a slot in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (w_pushOk) r_tail <= r_tail + 1'b1;
      if (w_pop)    r_head <= r_head + 1'b1;
      case ({w_pushOk, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
      else if (w_ovfClr)              r_ovf <= 1'b0;
      if (w_fault) r_err <= 1'b1;
    end
  end

  always_comb begin
    w_rdata = '0;
    if (data_read) begin
      if (w_fault) begin
        w_rdata = 32'hDEAD_BEEF;
      end else if (w_isRam) begin
        w_rdata = r_mem[w_idx];
      end else begin
        case (w_off)
          OFF_CYCLE: w_rdata = w_cycle;
          OFF_STAT:  w_rdata = w_status;
          default:   w_rdata = '0;
        endcase
      end
    end
  end

  assign data_in   = w_rdata;
  assign con_valid = !w_empty;
  assign con_data  = w_empty ? 32'h0 : r_fifo[r_head];
  assign err       = r_err;

endmodule

// File: tb/tb_scc_data_mem.sv
// Scoreboard bench for scc_data_mem: stimulus queues expected load/console words, a negedge monitor checks them.
module tb_scc_data_mem;

  localparam logic [31:0] BASE  = 32'hFFFF_FF00;
  localparam logic [31:0] CYC   = BASE + 32'h0;
  localparam logic [31:0] CONTX = BASE + 32'h4;
  localparam logic [31:0] STAT  = BASE + 32'h8;

  typedef struct {
    logic [31:0] val;
    string       name;
  } expT;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data_addr;
  logic [31:0] data_out;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_in;
  logic [31:0] con_data;
  logic        con_valid;
  logic        con_ready;
  logic        err;

  expT expQ[$];
  expT conQ[$];
  int  checks = 0;
  int  errors = 0;

  scc_data_mem #(.DEPTH(256), .FIFO_DEPTH(4), .MMIO_BASE(BASE)) dut (
    .clk(clk), .reset(reset), .data_addr(data_addr), .data_out(data_out),
    .data_read(data_read), .data_write(data_write), .data_in(data_in),
    .con_data(con_data), .con_valid(con_valid), .con_ready(con_ready), .err(err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Presents one bus cycle starting now (just after an edge) and returns just after the next edge.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] exp, input string name);
    expT e;
    data_read  = rd;
    data_write = wr;
    data_addr  = addr;
    data_out   = wdata;
    if (rd) begin
      e.val  = exp;
      e.name = name;
      expQ.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, "idle");
  endtask

  task automatic pushCon(input logic [31:0] v, input string name);
    expT e;
    e.val  = v;
    e.name = name;
    conQ.push_back(e);
  endtask

  // Monitor: each load is compared to the oldest queued expectation, each console handshake likewise.
  always @(negedge clk) begin
    expT e;
    if (data_read) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_load", data_in, 32'hXXXX_XXXX);
      end else begin
        e = expQ.pop_front();
        checkOutput(e.name, data_in, e.val);
      end
    end else begin
      checkOutput("idle_zero", data_in, 32'h0);
    end
    if (con_valid && con_ready) begin
      if (conQ.size() == 0) begin
        checkOutput("unexpected_pop", con_data, 32'hXXXX_XXXX);
      end else begin
        e = conQ.pop_front();
        checkOutput(e.name, con_data, e.val);
      end
    end
  end

  initial begin
    logic [31:0] c1;
    logic [31:0] c2;
`ifdef DMEM_CYCLE_COUNTER_EN
    c1 = 32'd1;
    c2 = 32'd2;
`else
    c1 = 32'd0;
    c2 = 32'd0;
`endif
    reset      = 1'b1;
    data_read  = 1'b0;
    data_write = 1'b0;
    data_addr  = 32'h0;
    data_out   = 32'h0;
    con_ready  = 1'b0;

    @(negedge clk);
    checkOutput("reset_con_valid", {31'b0, con_valid}, 32'h0);
    checkOutput("reset_con_data", con_data, 32'h0);
    checkOutput("reset_err", {31'b0, err}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    applyStimulus(1, 0, CYC, 0, 32'd0, "cycle_0");
    applyStimulus(1, 0, CYC, 0, c1, "cycle_1");
    applyStimulus(1, 0, CYC, 0, c2, "cycle_2");
    applyStimulus(1, 0, STAT, 0, 32'h1, "status_reset");

    applyStimulus(0, 1, CYC, 32'h55, 0, "");
    applyStimulus(1, 0, CONTX, 0, 32'h0, "contx_read");
    applyStimulus(1, 0, STAT, 0, 32'h1, "status_no_fault");

    applyStimulus(0, 1, 32'h10, 32'h1234_5678, 0, "");
    applyStimulus(1, 0, 32'h10, 0, 32'h1234_5678, "ram_load");
    idle();
    applyStimulus(0, 1, 32'h3FC, 32'hCAFE_F00D, 0, "");
    applyStimulus(1, 0, 32'h3FC, 0, 32'hCAFE_F00D, "ram_top_word");
    applyStimulus(1, 0, 32'h10, 0, 32'h1234_5678, "ram_load_again");

    applyStimulus(1, 0, 32'h12, 0, 32'hDEAD_BEEF, "misaligned");
    applyStimulus(1, 0, STAT, 0, 32'h9, "status_err");
    applyStimulus(0, 1, 32'h8000_0000, 32'h1111_1111, 0, "");
    applyStimulus(1, 1, 32'h10, 32'hFFFF_FFFF, 32'hDEAD_BEEF, "rd_wr_fault");
    applyStimulus(1, 0, 32'h10, 0, 32'h1234_5678, "ram_kept");
    applyStimulus(1, 0, BASE + 32'hC, 0, 32'hDEAD_BEEF, "mmio_hole");
    applyStimulus(1, 0, 32'h400, 0, 32'hDEAD_BEEF, "ram_end");
    applyStimulus(1, 0, STAT, 0, 32'h9, "err_sticky");

    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) pushCon(32'(i), "drain_seq");
      applyStimulus(0, 1, CONTX, 32'(i), 0, "");
    end
    applyStimulus(1, 0, STAT, 0, 32'h0000_040E, "status_full_ovf");
    con_ready = 1'b1;
    for (int i = 0; i < 4; i++) idle();
    applyStimulus(1, 0, STAT, 0, 32'hD, "status_drained");
    #2;
    checkOutput("drained_con_valid", {31'b0, con_valid}, 32'h0);
    applyStimulus(0, 1, STAT, 32'h4, 0, "");
    applyStimulus(1, 0, STAT, 0, 32'h9, "ovf_cleared");

    con_ready = 1'b0;
    for (int i = 10; i <= 13; i++) begin
      pushCon(32'(i), "full_seq");
      applyStimulus(0, 1, CONTX, 32'(i), 0, "");
    end
    applyStimulus(1, 0, STAT, 0, 32'h0000_040A, "status_full");
    con_ready = 1'b1;
    pushCon(32'd9, "full_seq_last");
    applyStimulus(0, 1, CONTX, 32'd9, 0, "");
    con_ready = 1'b0;
    applyStimulus(1, 0, STAT, 0, 32'h0000_040A, "full_push_pop");
    con_ready = 1'b1;
    for (int i = 0; i < 4; i++) idle();
    applyStimulus(1, 0, STAT, 0, 32'h9, "status_empty");

    con_ready = 1'b0;
    pushCon(32'd30, "one_seq");
    applyStimulus(0, 1, CONTX, 32'd30, 0, "");
    con_ready = 1'b1;
    pushCon(32'd31, "one_seq");
    applyStimulus(0, 1, CONTX, 32'd31, 0, "");
    applyStimulus(1, 0, STAT, 0, 32'h0000_0108, "count1_push_pop");
    applyStimulus(1, 0, STAT, 0, 32'h9, "count1_done");

    con_ready = 1'b0;
    for (int i = 21; i <= 23; i++) applyStimulus(0, 1, CONTX, 32'(i), 0, "");
    reset = 1'b1;
    applyStimulus(0, 1, 32'h10, 32'hAAAA_AAAA, 0, "");
    reset = 1'b0;
    #2;
    checkOutput("post_reset_con_valid", {31'b0, con_valid}, 32'h0);
    checkOutput("post_reset_con_data", con_data, 32'h0);
    checkOutput("post_reset_err", {31'b0, err}, 32'h0);
    applyStimulus(1, 0, STAT, 0, 32'h1, "status_after_reset");
    applyStimulus(1, 0, 32'h10, 0, 32'h1234_5678, "ram_retained");
    idle();

    checkOutput("load_queue_empty", 32'(expQ.size()), 32'h0);
    checkOutput("con_queue_empty", 32'(conQ.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
